vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, active pixels per line.
REQ-002 Parameter H_FRONT / H_SYNC / H_BACK, defaults 16 / 96 / 48, horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, default 480, active lines per frame.
REQ-004 Parameter V_FRONT / V_SYNC / V_BACK, defaults 10 / 2 / 33, vertical porch and sync widths in lines.
REQ-005 Parameter PIPELINE_DELAY, default 7, colour latency of the downstream pixel stage in clk cycles; legal range 1..15.
REQ-006 clk  in  1  pixel clock; the block's only clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 count_h  out  32 signed  horizontal position; 0 = first visible pixel.
REQ-009 count_v  out  32 signed  vertical position; 0 = first visible line.
REQ-010 frame_start  out  1  one-cycle pulse when count_h=0 and count_v=0.
REQ-011 color_in  in  8  RRRGGGBB pixel from the pixel stage, valid PIPELINE_DELAY cycles after the counts it was computed from.
REQ-012 vga_r / vga_g / vga_b  out  3 / 3 / 2  registered colour to the DAC pins.
REQ-013 vga_hs / vga_vs  out  1 / 1  sync outputs, active-low.
REQ-014 vga_de  out  1  data enable, high for visible pixels.

Function
REQ-015 H_TOTAL = sum of the four H parameters (800); V_TOTAL = sum of the four V parameters (525).
REQ-016 count_h increments every clk and wraps from H_TOTAL-1 to 0.
REQ-017 count_v increments only on the count_h wrap, and wraps from V_TOTAL-1 to 0 on the same edge where count_h wraps.
REQ-018 count_h and count_v are registered, never negative, with upper bits always zero.
REQ-019 Raw hs is low when H_VISIBLE+H_FRONT <= count_h < H_VISIBLE+H_FRONT+H_SYNC (656..751).
REQ-020 Raw vs is low when V_VISIBLE+V_FRONT <= count_v < V_VISIBLE+V_FRONT+V_SYNC (490..491).
REQ-021 Raw de is high when count_h < H_VISIBLE and count_v < V_VISIBLE.
REQ-022 Raw {hs, vs, de} is derived combinationally from the current count registers.
REQ-023 Raw {hs, vs, de} passes through a shift register of depth PIPELINE_DELAY+1.
REQ-024 A tap at depth PIPELINE_DELAY (de_tap) is aligned with color_in.
REQ-025 vga_r/g/b register color_in[7:5] / [4:2] / [1:0] when de_tap=1, and register 0 otherwise.
REQ-026 vga_hs, vga_vs and vga_de are the depth PIPELINE_DELAY+1 outputs, so they align exactly with vga_r/g/b.
REQ-027 Total latency from counts to pins is PIPELINE_DELAY+1 cycles (8 at default).
REQ-028 frame_start is undelayed, a registered pulse coincident with count_h=0, count_v=0.
REQ-029 No blanking gap exists at any wrap: line and frame boundaries are continuous.

Reset
REQ-030 While reset=0: count_h=0, count_v=0, frame_start=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_de=0.
REQ-031 While reset=0, every delay-line stage holds hs=1, vs=1, de=0.
REQ-032 Assertion mid-frame takes effect immediately, without waiting for a clk edge.
REQ-033 After reset release, the first clk edge moves count_h to 1.
REQ-034 After reset release, the first asserted vga_de appears PIPELINE_DELAY+1 cycles after release, with no partial sync pulse.

Verification
REQ-035 Release reset, hold color_in=0xFF -> vga_de first high at cycle 8 with r=7, g=7, b=3; frame_start seen at release cycle 0 and again 420000 cycles later.
REQ-036 Run one line -> vga_hs low for exactly 96 consecutive cycles, starting 8 cycles after count_h=656; vga_de high for 640 cycles per visible line.
REQ-037 Run one frame -> vga_vs low for exactly 2×800 cycles, starting 8 cycles after count_v becomes 490.
REQ-038 Check the wrap points -> count_h 799->0 increments count_v; at count_h=799, count_v=524 the next edge gives 0,0 with a frame_start pulse.
REQ-039 Drive color_in=0xA5 during blanking (de_tap=0) -> vga_r/g/b stay 0; drive 0xA5 when de_tap=1 -> r=5, g=1, b=1 one cycle later.
REQ-040 Assert reset at count_h=300, count_v=200 between clk edges -> all outputs at reset values immediately; after release, timing restarts from 0,0 as in REQ-035.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with sync/data-enable delayed to line up
// with a fixed-latency pixel stage, plus registered colour outputs.
module vga_timing_gen #(
    parameter int H_VISIBLE      = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_VISIBLE      = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int PIPELINE_DELAY = 7
) (
    input  logic               clk,
    input  logic               reset,
    output logic signed [31:0] count_h,
    output logic signed [31:0] count_v,
    output logic               frame_start,
    input  logic [7:0]         color_in,
    output logic [2:0]         vga_r,
    output logic [2:0]         vga_g,
    output logic [1:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          h_wrap;
    logic          v_wrap;
    logic [2:0]    raw;
    logic [2:0]    dly [PIPELINE_DELAY+1];
    logic          de_tap;

    assign h_wrap = h == H_LAST;
    assign v_wrap = v == V_LAST;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h <= '0;
            v <= '0;
        end else begin
            h <= h_wrap ? '0 : h + 1'b1;
            if (h_wrap)
                v <= v_wrap ? '0 : v + 1'b1;
        end
    end

    assign count_h     = 32'(h);
    assign count_v     = 32'(v);
    assign frame_start = reset && h == '0 && v == '0;

    // {hs, vs, de}; sync is active-low
    always_comb begin
        raw    = 3'b110;
        raw[2] = !(h >= HS_START && h < HS_END);
        raw[1] = !(v >= VS_START && v < VS_END);
        raw[0] = h < H_VIS && v < V_VIS;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= PIPELINE_DELAY; i++)
                dly[i] <= 3'b110;
        end else begin
            dly[0] <= raw;
            for (int i = 1; i <= PIPELINE_DELAY; i++)
                dly[i] <= dly[i-1];
        end
    end

    assign de_tap = dly[PIPELINE_DELAY-1][0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vga_r <= '0;
            vga_g <= '0;
            vga_b <= '0;
        end else begin
            vga_r <= de_tap ? color_in[7:5] : 3'd0;
            vga_g <= de_tap ? color_in[4:2] : 3'd0;
            vga_b <= de_tap ? color_in[1:0] : 2'd0;
        end
    end

    assign vga_hs = dly[PIPELINE_DELAY][2];
    assign vga_vs = dly[PIPELINE_DELAY][1];
    assign vga_de = dly[PIPELINE_DELAY][0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random colour and random mid-frame resets against a
// raster-position reference model on a reduced screen geometry.
module tb_vga_timing_gen;
    localparam int HV = 20, HF = 3, HS = 5, HB = 4;
    localparam int VV = 12, VF = 2, VS = 3, VB = 4;
    localparam int PD = 7;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FT = HT * VT;

    logic               clk = 0;
    logic               reset = 0;
    logic [7:0]         color_in = 0;
    logic signed [31:0] count_h, count_v;
    logic               frame_start;
    logic [2:0]         vga_r, vga_g;
    logic [1:0]         vga_b;
    logic               vga_hs, vga_vs, vga_de;

    int         errs = 0;
    int         checks = 0;
    int         t = 0;
    logic [7:0] col[$];

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .PIPELINE_DELAY(PD)
    ) dut (
        .clk(clk), .reset(reset), .count_h(count_h), .count_v(count_v),
        .frame_start(frame_start), .color_in(color_in),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            if (errs <= 20)
                $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
        end
    endtask

    // {hs, vs, de} expected on the pins for raster position p
    function automatic logic [2:0] raster(input int p);
        int h, v;
        h = p % HT;
        v = (p / HT) % VT;
        return {!(h >= HV + HF && h < HV + HF + HS),
                !(v >= VV + VF && v < VV + VF + VS),
                h < HV && v < VV};
    endfunction

    task automatic check_cycle();
        int         p;
        logic [2:0] e;
        logic [7:0] c;
        p = t % FT;
        e = (t >= PD + 1) ? raster(t - PD - 1) : 3'b110;
        c = (t >= PD + 1 && e[0]) ? col[t-1] : 8'h00;
        check("count_h", count_h, p % HT);
        check("count_v", count_v, p / HT);
        check("frame_start", {31'b0, frame_start}, {31'b0, p == 0});
        check("hs", {31'b0, vga_hs}, {31'b0, e[2]});
        check("vs", {31'b0, vga_vs}, {31'b0, e[1]});
        check("de", {31'b0, vga_de}, {31'b0, e[0]});
        check("rgb", {24'b0, vga_r, vga_g, vga_b}, {24'b0, c});
    endtask

    task automatic check_reset();
        check("rst_count_h", count_h, 0);
        check("rst_count_v", count_v, 0);
        check("rst_frame_start", {31'b0, frame_start}, 0);
        check("rst_rgb", {24'b0, vga_r, vga_g, vga_b}, 0);
        check("rst_sync_de", {29'b0, vga_hs, vga_vs, vga_de}, 32'h6);
    endtask

    task automatic drive_color();
        color_in = ($urandom_range(0, 3) == 0) ? 8'hA5 : 8'($urandom);
        col.push_back(color_in);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1;
        t = 0;
        col.delete();
        drive_color();
        #1 check_cycle();
    endtask

    task automatic step();
        @(posedge clk);
        t++;
        #1 drive_color();
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset();
        release_reset();
        repeat (2 * FT + 40) step();
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, FT)) step();
            #2 reset = 0;
            #1 check_reset();
            @(posedge clk);
            #1 check_reset();
            release_reset();
            repeat (FT + PD + 5) step();
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
